// File: rtl/deslocador_seq.sv
// rtl/deslocador_seq.sv - multi-cycle shifter/rotator that moves one bit per clock
module deslocador_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] E,
  input  logic [7:0]       control,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic [SHAMT_W-1:0] count;
  logic [2:0]         mode;     // latched control[7:5]: rotate, left, logical
  logic [WIDTH-1:0]   step_r;

  // One-bit step of the latched operation applied to the current R.
  always_comb begin
    step_r = R;
    if (mode[2]) begin
      if (mode[1]) step_r = {R[WIDTH-2:0], R[WIDTH-1]};
      else         step_r = {R[0], R[WIDTH-1:1]};
    end else if (mode[0]) begin
      if (mode[1]) step_r = {R[WIDTH-2:0], 1'b0};
      else         step_r = {1'b0, R[WIDTH-1:1]};
    end else begin
      // sign-preserving: MSB stays put, the remaining bits shift with zero fill
      if (mode[1]) step_r = {R[WIDTH-1], R[WIDTH-3:0], 1'b0};
      else         step_r = {R[WIDTH-1], 1'b0, R[WIDTH-2:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      R     <= '0;
      count <= '0;
      mode  <= '0;
    end else begin
      case (state)
        SHIFT: begin
          R     <= step_r;
          count <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) state <= DONE;
        end
        IDLE, DONE: begin
          if (start) begin
            R     <= E;
            mode  <= control[7:5];
            count <= control[SHAMT_W-1:0];
            state <= (control[SHAMT_W-1:0] == '0) ? DONE : SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_deslocador_seq.sv
// tb/tb_deslocador_seq.sv - self-checking bench for deslocador_seq
module tb_deslocador_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] E;
  logic [7:0]  control;
  logic [31:0] R;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  deslocador_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .E(E), .control(control),
    .R(R), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Closed-form result of applying k single-bit steps of operation ctl to e.
  function automatic logic [31:0] apply_op(logic [31:0] e, logic [7:0] ctl, int k);
    logic [31:0] hi;
    if (k == 0) return e;
    hi = e & 32'h8000_0000;
    if (ctl[7]) begin
      if (ctl[6]) return (e << k) | (e >> (32 - k));
      else        return (e >> k) | (e << (32 - k));
    end
    if (ctl[5]) return ctl[6] ? (e << k) : (e >> k);
    if (ctl[6]) return hi | ((e << k) & 32'h7FFF_FFFF);
    return hi | ((e & 32'h7FFF_FFFF) >> k);
  endfunction

  // Reference model: 0 idle, 1 shifting, 2 done.
  int          m_state = 0;
  int          m_k = 0;
  logic [31:0] m_e = '0;
  logic [7:0]  m_ctl = '0;
  logic [31:0] m_r = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = 0; m_k = 0; m_e = '0; m_ctl = '0; m_valid = 1'b1;
    end else if (start && m_state != 1) begin
      m_e = E; m_ctl = control; m_k = 0;
      m_state = (control[4:0] == 0) ? 2 : 1;
    end else if (m_state == 1) begin
      m_k++;
      if (m_k == int'(m_ctl[4:0])) m_state = 2;
    end else begin
      m_state = 0;
    end
    m_r = apply_op(m_e, m_ctl, m_k);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", {31'd0, busy}, {31'd0, m_state == 1});
      check("model_done", {31'd0, done}, {31'd0, m_state == 2});
      check("model_r", R, m_r);
    end
  end

  // Drive an accepted start at the current negedge; scramble inputs afterwards.
  task automatic issue(logic [31:0] e, logic [7:0] ctl);
    E = e; control = ctl; start = 1'b1;
    @(negedge clk);
    start = 1'b0; E = $urandom; control = 8'($urandom);
  endtask

  // Wait for done (first negedge after issue counts as cycle 1); inj>0 pulses a stray start.
  task automatic wait_done(string name, logic [31:0] exp_r, int exp_lat, int exp_busy, int inj);
    int lat = 1;
    int bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      start = (lat == inj);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, bcnt, exp_busy);
    check({name, "_result"}, R, exp_r);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; E = '0; control = '0;
    repeat (3) @(negedge clk);
    check("reset_r", R, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h8000_0001, 8'h81);
    wait_done("rotr1", 32'hC000_0000, 2, 1, 0);
    @(negedge clk);

    issue(32'h1234_5678, 8'hC8);
    wait_done("rotl8", 32'h3456_7812, 9, 8, 0);
    @(negedge clk);

    issue(32'h8000_00F0, 8'h04);
    wait_done("sar4", 32'h8000_000F, 5, 4, 0);
    repeat (2) @(negedge clk);
    check("idle_hold", R, 32'h8000_000F);

    issue(32'hFFFF_FFFF, 8'h3F);
    wait_done("shr31_ignored_start", 32'h0000_0001, 32, 31, 5);
    @(negedge clk);

    issue(32'hDEAD_BEEF, 8'h20);
    wait_done("n0", 32'hDEAD_BEEF, 1, 0, 0);
    issue(32'h0000_000F, 8'h42);
    wait_done("b2b_sal2", 32'h0000_003C, 3, 2, 0);
    @(negedge clk);

    issue(32'hC000_0001, 8'h44);
    wait_done("sal4", 32'h8000_0010, 5, 4, 0);
    @(negedge clk);

    issue(32'h0000_0001, 8'hDF);
    wait_done("rotl31", 32'h8000_0000, 32, 31, 0);
    @(negedge clk);

    // Reset during cycle 3 of a 10-step rotate, with a start that must be ignored.
    issue(32'hA5A5_A5A5, 8'h8A);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; start = 1'b1; E = 32'h1111_1111; control = 8'h21;
    @(negedge clk);
    start = 1'b0;
    check("midrst_r", R, 32'h0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_done", {31'd0, done}, 32'd0);
    end

    issue(32'h0000_0001, 8'h61);
    wait_done("after_rst_shl1", 32'h0000_0002, 2, 1, 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
